// File: rtl/rtu_pkg.sv
// Shared types and default frame geometry for the ray-tracing frame sequencer
// and the frame-buffer controller.
package rtu_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } sched_state_t;

  localparam int H_RES_DEF   = 320;
  localparam int V_RES_DEF   = 240;
  localparam int COLOR_W_DEF = 12;

  // Index width that stays legal for single-entry vectors.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rtu_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from a rotating priority pointer;
// the pointer moves past the winner only when the grant is taken (advance).
module rr_arbiter
  import rtu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [N-1:0]  mask;
  logic [N-1:0]  hi_req;
  logic [N-1:0]  pick;
  logic          found;

  // Requests at or above the pointer win first; otherwise wrap to the lowest.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr));
    hi_req = req & mask;
    pick   = (|hi_req) ? hi_req : req;
    gnt    = '0;
    win    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pick[i] && !found) begin
        gnt[i] = 1'b1;
        win    = PW'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance && found) ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
  end

endmodule

// File: rtl/rtu_job_scheduler.sv
// Frame sequencer: walks pixels in raster order, issues each to the lowest free RTU,
// and funnels RTU results round-robin onto the single frame-buffer write port.
//
//   state      | meaning
//   S_IDLE     | waiting for start
//   S_DISPATCH | issuing pixels, collecting results
//   S_DRAIN    | all pixels issued, collecting the remaining results
//   S_DONE     | one-cycle frame_done pulse
module rtu_job_scheduler
  import rtu_pkg::*;
#(
  parameter  int NUM_RTU = 4,
  parameter  int H_RES   = H_RES_DEF,
  parameter  int V_RES   = V_RES_DEF,
  parameter  int COLOR_W = COLOR_W_DEF,
  localparam int X_W     = $clog2(H_RES),
  localparam int Y_W     = $clog2(V_RES),
  localparam int FB_AW   = $clog2(H_RES * V_RES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       frame_done,
  input  logic [NUM_RTU-1:0]         rtu_idle,
  output logic [NUM_RTU-1:0]         rtu_go,
  output logic [X_W-1:0]             rtu_x,
  output logic [Y_W-1:0]             rtu_y,
  input  logic [NUM_RTU-1:0]         res_valid,
  input  logic [NUM_RTU*COLOR_W-1:0] res_color,
  output logic [NUM_RTU-1:0]         res_ack,
  output logic                       fb_we,
  output logic [FB_AW-1:0]           fb_addr,
  output logic [COLOR_W-1:0]         fb_wdata,
  input  logic                       fb_ready
);

  sched_state_t state, state_nxt;

  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [NUM_RTU-1:0] slot_busy;
  logic [FB_AW-1:0]   slot_addr [NUM_RTU];

  logic [NUM_RTU-1:0] free_slot;
  logic [NUM_RTU-1:0] go;
  logic [NUM_RTU-1:0] req;
  logic [NUM_RTU-1:0] gnt;
  logic               issue;
  logic               last_px;
  logic               active;
  logic               adv;
  logic               grant;
  logic [FB_AW-1:0]   cur_addr;
  logic [FB_AW-1:0]   sel_addr;
  logic [COLOR_W-1:0] sel_color;

  assign active    = (state == S_DISPATCH) || (state == S_DRAIN);
  assign free_slot = rtu_idle & ~slot_busy;
  assign issue     = |go;
  assign last_px   = (x == X_W'(H_RES - 1)) && (y == Y_W'(V_RES - 1));
  assign cur_addr  = FB_AW'(y) * FB_AW'(H_RES) + FB_AW'(x);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_DISPATCH;
      S_DISPATCH: if (issue && last_px) state_nxt = S_DRAIN;
      S_DRAIN:    if (slot_busy == '0 && !fb_we) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Lowest-index free slot gets the job; scanned high to low so the lowest sticks.
  always_comb begin
    go = '0;
    if (state == S_DISPATCH) begin
      for (int i = NUM_RTU - 1; i >= 0; i--) begin
        if (free_slot[i]) begin
          go    = '0;
          go[i] = 1'b1;
        end
      end
    end
  end

  // A grant is only taken when the write register is empty or draining this cycle.
  assign adv   = active && (!fb_we || fb_ready);
  assign req   = active ? (res_valid & slot_busy) : '0;
  assign grant = adv && (|gnt);

  rr_arbiter #(.N(NUM_RTU)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (adv),
    .gnt     (gnt)
  );

  always_comb begin
    sel_addr  = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_RTU; i++) begin
      if (gnt[i]) begin
        sel_addr  = slot_addr[i];
        sel_color = res_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      slot_busy <= '0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
      for (int i = 0; i < NUM_RTU; i++) slot_addr[i] <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        x <= '0;
        y <= '0;
      end else if (issue) begin
        if (x == X_W'(H_RES - 1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      for (int i = 0; i < NUM_RTU; i++) begin
        if (go[i]) begin
          slot_busy[i] <= 1'b1;
          slot_addr[i] <= cur_addr;
        end else if (grant && gnt[i]) begin
          slot_busy[i] <= 1'b0;
        end
      end
      if (grant) begin
        fb_we    <= 1'b1;
        fb_addr  <= sel_addr;
        fb_wdata <= sel_color;
      end else if (fb_we && fb_ready) begin
        fb_we <= 1'b0;
      end
    end
  end

  assign busy       = active;
  assign frame_done = (state == S_DONE);
  assign rtu_go     = go;
  assign rtu_x      = x;
  assign rtu_y      = y;
  assign res_ack    = adv ? gnt : '0;

endmodule

// File: tb/tb_rtu_job_scheduler.sv
// Bench for rtu_job_scheduler: a single-RTU 4x2 frame plus a 4-RTU 40x30 instance driven by
// modelled RTUs and compared every cycle against a transaction-level scheduler model.
module tb_rtu_job_scheduler;

  localparam int N   = 4;
  localparam int H   = 40;
  localparam int V   = 30;
  localparam int CW  = 12;
  localparam int NPX = H * V;
  localparam int XW  = $clog2(H);
  localparam int YW  = $clog2(V);
  localparam int AW  = $clog2(NPX);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, frame_done, fb_we, fb_ready;
  logic [N-1:0]  rtu_idle, rtu_go, res_valid, res_ack;
  logic [XW-1:0] rtu_x;
  logic [YW-1:0] rtu_y;
  logic [N*CW-1:0] res_color;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_wdata;

  logic        s_start, s_busy, s_done, s_idle, s_go, s_valid, s_ack, s_we, s_ready;
  logic [1:0]  s_x;
  logic [0:0]  s_y;
  logic [11:0] s_color, s_wdata;
  logic [2:0]  s_addr;

  rtu_job_scheduler #(.NUM_RTU(N), .H_RES(H), .V_RES(V), .COLOR_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .rtu_idle(rtu_idle), .rtu_go(rtu_go), .rtu_x(rtu_x), .rtu_y(rtu_y),
    .res_valid(res_valid), .res_color(res_color), .res_ack(res_ack),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready)
  );

  rtu_job_scheduler #(.NUM_RTU(1), .H_RES(4), .V_RES(2), .COLOR_W(12)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .frame_done(s_done),
    .rtu_idle(s_idle), .rtu_go(s_go), .rtu_x(s_x), .rtu_y(s_y),
    .res_valid(s_valid), .res_color(s_color), .res_ack(s_ack),
    .fb_we(s_we), .fb_addr(s_addr), .fb_wdata(s_wdata), .fb_ready(s_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] color_of(input int a);
    return CW'(a * 37 + 5);
  endfunction

  // RTU environment: 0 idle, 1 computing, 2 result waiting for ack
  int rs_st [N];
  int rs_cnt [N];
  int rs_addr [N];
  logic [N-1:0] hold, en, spur;
  int lat_fix, rdy_mode;
  logic [N-1:0] g_go, g_ack;
  int g_px;
  logic g_rst, rst_req, start_req;

  // Scheduler model: phase 0 idle, 1 issuing, 2 waiting for outstanding work, 3 done pulse
  int m_phase, m_next, m_ptr, m_waddr;
  logic [N-1:0] m_busy;
  int m_addr [N];
  logic m_we;
  logic [CW-1:0] m_wdata;

  int wr_cnt [NPX];
  int n_done, n_spur_ack;

  task automatic model_reset();
    m_phase = 0; m_next = 0; m_ptr = 0; m_busy = '0; m_we = 1'b0; m_waddr = 0; m_wdata = '0;
    for (int i = 0; i < N; i++) m_addr[i] = 0;
  endtask

  task automatic step();
    logic [N-1:0] free, e_go, e_ack;
    int gsel, w, j;
    bit drain_ok;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (g_rst) rs_st[i] = 0;
      else begin
        if (g_ack[i]) rs_st[i] = 0;
        if (g_go[i]) begin
          rs_st[i] = 1;
          rs_cnt[i] = (lat_fix > 0) ? lat_fix : int'($urandom_range(20, 1));
          rs_addr[i] = g_px;
        end
        if (rs_st[i] == 1) begin
          if (rs_cnt[i] > 0) rs_cnt[i]--;
          if (rs_cnt[i] == 0 && !hold[i]) rs_st[i] = 2;
        end
      end
      rtu_idle[i] = (rs_st[i] == 0) && en[i];
      res_valid[i] = (rs_st[i] == 2) || spur[i];
      res_color[i*CW +: CW] = color_of(rs_addr[i]);
    end
    fb_ready = (rdy_mode == 2) ? ($urandom_range(99, 0) < 70) : rdy_mode[0];
    rst = rst_req; start = start_req; rst_req = 1'b0; start_req = 1'b0;
    #4;
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("frame_done", frame_done, (m_phase == 3));
    free = rtu_idle & ~m_busy;
    gsel = -1;
    if (m_phase == 1) for (int i = N - 1; i >= 0; i--) if (free[i]) gsel = i;
    e_go = '0;
    if (gsel >= 0) e_go[gsel] = 1'b1;
    chk("rtu_go", rtu_go, e_go);
    if (gsel >= 0) begin
      chk("rtu_x", rtu_x, m_next % H);
      chk("rtu_y", rtu_y, m_next / H);
    end
    w = -1;
    if ((m_phase == 1 || m_phase == 2) && (!m_we || fb_ready))
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && res_valid[j] && m_busy[j]) w = j;
      end
    e_ack = '0;
    if (w >= 0) e_ack[w] = 1'b1;
    chk("res_ack", res_ack, e_ack);
    chk("fb_we", fb_we, m_we);
    if (m_we) begin
      chk("fb_addr", fb_addr, m_waddr);
      chk("fb_wdata", fb_wdata, m_wdata);
    end
    if (fb_we && fb_ready) begin
      if (int'(fb_addr) < NPX) wr_cnt[fb_addr]++;
      chk("wr_color", fb_wdata, color_of(int'(fb_addr)));
    end
    if (frame_done) n_done++;
    if (res_ack[N-1] && spur[N-1]) n_spur_ack++;
    g_go = rtu_go; g_ack = res_ack; g_rst = rst;
    g_px = int'(rtu_y) * H + int'(rtu_x);
    if (rst) model_reset();
    else begin
      drain_ok = (m_busy == '0) && !m_we;
      if (w >= 0) begin
        m_we = 1'b1; m_waddr = m_addr[w]; m_wdata = res_color[w*CW +: CW];
        m_busy[w] = 1'b0; m_ptr = (w + 1) % N;
      end else if (m_we && fb_ready) m_we = 1'b0;
      if (gsel >= 0) begin
        m_busy[gsel] = 1'b1; m_addr[gsel] = m_next; m_next++;
      end
      case (m_phase)
        0: if (start) begin m_phase = 1; m_next = 0; end
        1: if (m_next == NPX) m_phase = 2;
        2: if (drain_ok) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic sb_check(input string name);
    int nb;
    nb = 0;
    for (int a = 0; a < NPX; a++) if (wr_cnt[a] != 1) nb++;
    chk(name, nb, 0);
    chk({name, "_done_once"}, n_done, 1);
  endtask

  task automatic sb_clear();
    for (int a = 0; a < NPX; a++) wr_cnt[a] = 0;
    n_done = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_go_n, s_exp, s_done_n, s_done_c, s_rdy_at, s_raddr, s_px_prev;
    bit s_rtu_busy, s_go_prev, s_ack_prev;

    rst = 1'b1; start = 1'b0; rtu_idle = '1; res_valid = '0; res_color = '0; fb_ready = 1'b1;
    s_start = 1'b0; s_idle = 1'b1; s_valid = 1'b0; s_color = '0; s_ready = 1'b1;
    hold = '0; en = '1; spur = '0; lat_fix = 0; rdy_mode = 1;
    g_go = '0; g_ack = '0; g_px = 0; g_rst = 1'b1; rst_req = 1'b1; start_req = 1'b0;
    n_spur_ack = 0;
    for (int i = 0; i < N; i++) begin rs_st[i] = 0; rs_cnt[i] = 0; rs_addr[i] = 0; end
    model_reset();
    sb_clear();

    rst_req = 1'b1; step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_go", rtu_go, 0);
    chk("rst_ack", res_ack, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_xy", {rtu_x, rtu_y}, 0);

    // single RTU, 4x2 frame, result 3 cycles after go, colour = address
    s_go_n = 0; s_exp = 0; s_done_n = 0; s_done_c = 0; s_rdy_at = 0; s_raddr = 0;
    s_px_prev = 0; s_rtu_busy = 0; s_go_prev = 0; s_ack_prev = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      s_start = (c == 0);
      if (s_ack_prev) s_rtu_busy = 0;
      if (s_go_prev) begin s_rtu_busy = 1; s_rdy_at = c + 2; s_raddr = s_px_prev; end
      s_idle = !s_rtu_busy;
      s_valid = s_rtu_busy && (c >= s_rdy_at);
      s_color = 12'(s_raddr);
      #4;
      if (s_go) s_go_n++;
      if (s_we && s_ready) begin
        chk("t1_addr", s_addr, s_exp);
        chk("t1_wdata", s_wdata, s_exp);
        s_exp++;
      end
      if (s_done) begin s_done_n++; s_done_c = c; end
      s_go_prev = s_go; s_ack_prev = s_ack;
      s_px_prev = int'(s_y) * 4 + int'(s_x);
      if (s_done_n > 0 && c >= s_done_c + 4) break;
    end
    chk("t1_go_count", s_go_n, 8);
    chk("t1_write_count", s_exp, 8);
    chk("t1_done_count", s_done_n, 1);
    chk("t1_busy_after", s_busy, 0);

    // all four RTUs idle: issue to slots 0..3 on consecutive cycles
    sb_clear();
    hold = '1; lat_fix = 1; rdy_mode = 1;
    start_req = 1'b1; step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_go", rtu_go, 32'(1 << k));
      chk("t2_x", rtu_x, k);
      chk("t2_y", rtu_y, 0);
    end
    step(); step();

    // four results at once: round-robin acks and back-to-back writes
    lat_fix = 20; hold = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 4) chk("t3_ack", res_ack, 32'(1 << k));
      if (k >= 1 && k <= 4) begin
        chk("t3_we", fb_we, 1);
        chk("t3_addr", fb_addr, k - 1);
      end
      if (k == 5) chk("t3_we_end", fb_we, 0);
    end
    hold = '1;

    // stall: write for slot 1 (pixel 5) held while slot 2 (pixel 6) waits
    for (int k = 0; k < 25; k++) step();
    hold = 4'b1001; rdy_mode = 0;
    step();
    chk("t4_first_ack", res_ack, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_we_held", fb_we, 1);
      chk("t4_addr_held", fb_addr, 5);
      chk("t4_data_held", fb_wdata, color_of(5));
      chk("t4_no_ack", res_ack, 0);
    end
    rdy_mode = 1;
    step();
    chk("t4_resume_ack", res_ack, 4'b0100);
    step();
    chk("t4_resume_addr", fb_addr, 6);
    chk("t4_resume_data", fb_wdata, color_of(6));

    // finish the frame randomly; pulse start while draining
    hold = '0; lat_fix = 0; rdy_mode = 2;
    for (int i = 0; i < 20000 && m_phase != 2; i++) step();
    start_req = 1'b1; step();
    chk("t5_busy_in_drain", busy, 1);
    for (int i = 0; i < 2000 && n_done == 0; i++) step();
    step(); step();
    chk("t5_busy_after", busy, 0);
    sb_check("frame1_once");

    // reset in the middle of issuing, then restart at (0,0)
    start_req = 1'b1; step();
    for (int i = 0; i < 40; i++) step();
    chk("t5_busy_mid", busy, 1);
    rst_req = 1'b1; step();
    step();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", frame_done, 0);
    chk("t5_rst_go", rtu_go, 0);
    chk("t5_rst_ack", res_ack, 0);
    chk("t5_rst_we", fb_we, 0);
    chk("t5_rst_addr", fb_addr, 0);
    chk("t5_rst_wdata", fb_wdata, 0);
    chk("t5_rst_xy", {rtu_x, rtu_y}, 0);

    // random frame with slot 3 disabled but asserting a stray res_valid
    sb_clear();
    en = 4'b0111; spur = 4'b1000;
    start_req = 1'b1; step();
    step();
    chk("t6_first_go", rtu_go, 4'b0001);
    chk("t6_first_xy", {rtu_x, rtu_y}, 0);
    for (int i = 0; i < 30000 && n_done == 0; i++) step();
    step(); step();
    chk("t6_busy_after", busy, 0);
    chk("t6_stray_ack", n_spur_ack, 0);
    sb_check("frame2_once");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
